uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  Serial transmitter directly downstream of fifo_interleaved. Pops one byte at a time from the
//  FIFO read side and shifts it out on tx_o as 8N1 (1 start, 8 data LSB-first, 1 stop).
//  Returns a one-cycle ack per byte taken, which is the FIFO's pop strobe.
// PARAMETERS
//  BaudDiv   config_pkg::UartBaudDiv (default 868 = 100 MHz / 115200)   clock cycles per bit; legal >= 2
// PORTS
//  clk_i         in   1  system clock
//  reset_i       in   1  synchronous, active-high reset
//  fifo_data_i   in   8  byte at FIFO head; valid only while fifo_empty_i = 0
//  fifo_empty_i  in   1  1 = FIFO holds no byte
//  ack_o         out  1  one-cycle pulse: head byte consumed; FIFO advances its head
//  tx_o          out  1  serial line; idle/mark = 1
//  busy_o        out  1  1 while a frame is in flight (START..STOP)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset values: tx_o=1, ack_o=0, busy_o=0, state=IDLE, baud counter=0, bit index=0.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - FSM states: IDLE, START, DATA, STOP.
//    IDLE : on an edge with fifo_empty_i=0: latch fifo_data_i into shift reg, ack_o<=1 for exactly
//           one cycle, tx_o<=0, busy_o<=1, baud counter<=0, -> START. Otherwise hold, tx_o=1.
//    START: tx_o=0 for BaudDiv cycles; on tick -> DATA, bit index=0, tx_o<=shift[0].
//    DATA : each bit held BaudDiv cycles; on tick shift right, bit index+1; after bit 7 tick -> STOP, tx_o<=1.
//    STOP : tx_o=1 for BaudDiv cycles; on tick -> IDLE, busy_o<=0.
//  - Baud tick: counter runs 0..BaudDiv-1; tick when count==BaudDiv-1, then wraps to 0. Counter is
//    cleared on frame start, so the start bit begins exactly one cycle after the sampling edge.
//  - Latency: tx_o falls in the same cycle ack_o is high. Frame = 10*BaudDiv cycles.
//  - Back-to-back: IDLE samples fifo_empty_i in the cycle after STOP ends. Ack spacing for a
//    continuously non-empty FIFO is 10*BaudDiv+1 cycles. Never ack twice within one frame.
//  - FIFO head update: the FIFO may take 1 cycle after ack_o to present the next byte and update
//    empty. Guaranteed because the next sample is >= 10*BaudDiv cycles later.
//  - fifo_data_i / fifo_empty_i changes mid-frame are ignored. Only the latched copy is sent.
//  - Reset mid-frame: next cycle tx_o=1, busy_o=0, ack_o=0, IDLE.
//    The partially sent byte is dropped; the FIFO is reset by the same reset_i.
//  - Reset asserted in the same cycle as a sample opportunity: reset wins, no ack.
//  - BaudDiv < 2 is illegal: elaboration-time assertion.
// STRUCTURE
//  - config_pkg: UartClkHz, UartBaud, UartBaudDiv = UartClkHz/UartBaud, UartDataBits=8.
//  - uart_pkg:   typedef enum logic [1:0] {IDLE,START,DATA,STOP} uart_tx_state_t.
//  - Sub-module uart_baud_gen (clk_i, reset_i, clear_i -> tick_o), counter width $clog2(BaudDiv).
//    Reused later by uart_rx.
//  - Top integration: fifo_interleaved.ack <= uart_tx.ack_o.
// TESTING (bench tb_uart_tx, BaudDiv=4, 20 ns clock; optional fifo_interleaved instance for item 5)
//  1 Reset: hold reset_i 3 cycles with fifo_empty_i=0 -> tx_o=1, ack_o=0, busy_o=0 throughout.
//  2 Single byte 0xEF, empty=0 then empty=1 after ack ->
//    exactly one ack pulse; tx_o = 0,1,1,1,1,0,1,1,1,1, each level 4 cycles; busy_o high 40 cycles.
//  3 Empty FIFO: fifo_empty_i=1 for 100 cycles -> no ack, tx_o=1, busy_o=0.
//  4 Back-to-back 0xDE,0xAD,0xBE,0xEF with empty=0 ->
//    4 acks spaced 41 cycles; decoded line bytes DE,AD,BE,EF in order.
//  5 Integrated with fifo_interleaved: write 0xDEADBEEF width 4 ->
//    4 frames whose byte order matches FIFO pop order; no lost/duplicated byte; FIFO empty after 4th ack.
//  6 Reset in DATA bit 3 of 0x55 -> tx_o=1 next cycle, IDLE. Next byte 0xA5 sent as a clean full frame.
//    fifo_data_i toggled mid-frame does not alter transmitted bits.

Source files
------------

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - system-wide clock and UART link configuration
package config_pkg;

    localparam int UartClkHz    = 100_000_000;
    localparam int UartBaud     = 115_200;
    localparam int UartBaudDiv  = UartClkHz / UartBaud;
    localparam int UartDataBits = 8;

endpackage : config_pkg

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - FIFO read-side handshake between a byte FIFO and the transmitter
interface uart_tx_if;

    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       ack;

    modport master (
        output fifo_data,
        output fifo_empty,
        input  ack
    );

    modport slave (
        input  fifo_data,
        input  fifo_empty,
        output ack
    );

endinterface : uart_tx_if

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running bit-period counter, tick on the last cycle of each bit
module uart_baud_gen #(
    parameter int BaudDiv = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CntW = (BaudDiv > 2) ? $clog2(BaudDiv) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BaudDiv - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign tick_o = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter popping one byte per frame from a FIFO head
module uart_tx
    import config_pkg::*;
    import uart_pkg::*;
#(
    parameter int BaudDiv = UartBaudDiv
) (
    input  logic     clk_i,
    input  logic     reset_i,
    uart_tx_if.slave fifo_if,
    output logic     tx_o,
    output logic     busy_o
);

    localparam int BitIdxW = $clog2(UartDataBits);
    localparam logic [BitIdxW-1:0] LastBit = BitIdxW'(UartDataBits - 1);

    if (BaudDiv < 2) begin : g_bad_baud_div
        $error("uart_tx: BaudDiv must be at least 2");
    end

    uart_tx_state_t           state_q, state_d;
    logic [UartDataBits-1:0]  shift_q, shift_d;
    logic [BitIdxW-1:0]       bit_idx_q, bit_idx_d;
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;
    logic                     ack_q, ack_d;
    logic                     baud_clear;
    logic                     baud_tick;

    // Held clear while idle so the start bit gets a full period from the sampling edge.
    uart_baud_gen #(
        .BaudDiv (BaudDiv)
    ) u_baud_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (baud_clear),
        .tick_o  (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        baud_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                baud_clear = 1'b1;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                if (!fifo_if.fifo_empty) begin
                    shift_d = fifo_if.fifo_data;
                    ack_d   = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == LastBit) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + BitIdxW'(1);
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
        end
    end

    assign tx_o        = tx_q;
    assign busy_o      = busy_q;
    assign fifo_if.ack = ack_q;

endmodule : uart_tx
